ex_muldiv_ctrl: RTL and testbench
=================================

Name: ex_muldiv_ctrl

Overview:
Iterative RV32M multiply/divide sequencer attached to the EX stage. EX hands it R-type instructions with funct7 = 0000001. It latches the operands and runs a 32-iteration shift-add multiply or restoring divide. While it runs it holds the pipeline via stall_o to ctrl, then presents a one-cycle result to EX for write-back on reg_w_addr_o. A jump or flush from ctrl aborts the operation in flight.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, 5, iteration counter width (log2 XLEN)

Ports:
clk  in  1  clock, rising edge
arst  in  1  reset, asynchronous, active-high
start_i  in  1  EX request; valid M-extension instruction present
op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op1_i  in  XLEN  rs1 value (forwarded)
op2_i  in  XLEN  rs2 value (forwarded)
reg_w_addr_i  in  5  destination register
flush_i  in  1  abort from ctrl (taken jump / pipeline flush)
stall_o  out  1  hold IF/ID/EX registers
busy_o  out  1  state is neither IDLE nor DONE
result_valid_o  out  1  result_o valid, one-cycle pulse
result_o  out  XLEN  rd write data
reg_w_addr_o  out  5  latched destination register

Behaviour:
- Reset (arst high, async): state IDLE; counter 0; all outputs 0; internal operand, accumulator and sign registers 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start_i=1 and flush_i=0 at edge T0: latch op, reg_w_addr, operand magnitudes and sign flags; go to CALC.
  - Signed ops: DIV, REM, MULH, and op1 only for MULHSU. Unsigned ops take raw values.
  - Special divide cases are detected at T0 and go directly to DONE:
    - divisor 0: quotient 0xFFFFFFFF, remainder = op1.
    - DIV/REM with op1 = 0x80000000 and op2 = 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- CALC: one iteration per cycle for counter 0..31, i.e. cycles T1..T32.
  - Multiply: 64-bit shift-add on magnitudes.
  - Divide: restoring step; shift remainder left, subtract divisor, keep the result if non-negative, shift in the quotient bit.
  - At counter 31 go to FIX. The counter wraps to 0.
- FIX (T33): apply sign correction by negating.
  - Product: negate if the operand signs differ (MULHSU: sign of op1 only).
  - Quotient: negate if the signs differ.
  - Remainder: takes the sign of the dividend.
  - Select the result: MUL = low word; MULH/MULHSU/MULHU = high word; DIV/DIVU = quotient; REM/REMU = remainder. Register it into result_o. Go to DONE.
- DONE (T34 normal, T1 special): result_valid_o=1 for exactly this cycle, then go to IDLE. result_o and reg_w_addr_o hold until the next accept.
- Latency: 34 cycles from accept to result_valid for normal ops; 1 cycle for special cases.
- stall_o = (state==IDLE & start_i & ~flush_i) | state==CALC | state==FIX.
  - stall_o is low in DONE, so EX advances and consumes the result that cycle.
- busy_o = state in {CALC, FIX}.
- start_i while busy or in DONE: ignored; no queuing.
- flush_i in any state: next state IDLE, no result_valid pulse, counter cleared.
  - flush_i and start_i together in IDLE: flush wins, nothing is accepted.
  - flush_i in DONE: result_valid_o is suppressed combinationally that cycle.
- arst mid-operation: immediate return to IDLE, outputs 0, no partial result.
- All arithmetic is XLEN or 2*XLEN unsigned. Negation is two's complement; overflow wraps silently.

Decomposition:
- Shared define.v additions:
  - `INST_FUNCT7_M 7'b0000001
  - `INST_MUL..`INST_REMU funct3 codes
  - MD state encodings `MD_IDLE/`MD_CALC/`MD_FIX/`MD_DONE (2 bits)
  - `MD_ITER 32
- One sub-module is natural: ex_muldiv_step, a combinational single iteration for both shift-add and restoring-subtract, selected by is_div.
- FSM, counter, sign handling and result mux stay in the top level.

Test Plan:
1. MUL op1=7, op2=0xFFFFFFFD at T0 -> stall_o high T0..T33, result_valid_o at T34 with result_o=0xFFFFFFEB and reg_w_addr_o echoed.
2. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
3. DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
4. DIVU 5/0 -> result_valid_o at T1 with 0xFFFFFFFF, stall_o high only at T0; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, both at T1.
5. flush_i at CALC counter 10 -> IDLE next cycle, no result_valid_o, stall_o drops. A new MUL 3*4 issued next cycle -> 12 at +34.
6. arst pulsed at counter 20, plus start_i held high during CALC and start_i+flush_i together in IDLE -> outputs 0, extra start ignored, no accept respectively.

Source files
------------

// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared RV32M encodings, sequencer state codes and operand-class helpers
// for the iterative multiply/divide unit.
package ex_muldiv_ctrl_pkg;

  localparam int unsigned MD_XLEN  = 32;
  localparam int unsigned MD_CNT_W = 5;
  localparam int unsigned MD_ITER  = 32;

  localparam logic [6:0] INST_FUNCT7_M = 7'b0000001;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_CALC = 2'd1;
  localparam logic [1:0] MD_FIX  = 2'd2;
  localparam logic [1:0] MD_DONE = 2'd3;

  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic md_op1_signed(input logic [2:0] op);
    return (op == INST_MULH) || (op == INST_MULHSU) ||
           (op == INST_DIV)  || (op == INST_REM);
  endfunction

  function automatic logic md_op2_signed(input logic [2:0] op);
    return (op == INST_MULH) || (op == INST_DIV) || (op == INST_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// EX-stage request/response bundle between the pipeline and the mul/div unit.
interface ex_muldiv_ctrl_if;
  import ex_muldiv_ctrl_pkg::*;

  logic               start_i;
  logic [2:0]         op_i;
  logic [MD_XLEN-1:0] op1_i;
  logic [MD_XLEN-1:0] op2_i;
  logic [4:0]         reg_w_addr_i;
  logic               busy_o;
  logic               result_valid_o;
  logic [MD_XLEN-1:0] result_o;
  logic [4:0]         reg_w_addr_o;

  modport master (
    output start_i, op_i, op1_i, op2_i, reg_w_addr_i,
    input  busy_o, result_valid_o, result_o, reg_w_addr_o
  );

  modport slave (
    input  start_i, op_i, op1_i, op2_i, reg_w_addr_i,
    output busy_o, result_valid_o, result_o, reg_w_addr_o
  );
endinterface

// File: rtl/ex_muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide step
// on the {hi, lo} accumulator.
module ex_muldiv_step
  import ex_muldiv_ctrl_pkg::*;
(
  input  logic                   is_div_i,
  input  logic [2*MD_XLEN-1:0]   acc_i,
  input  logic [MD_XLEN-1:0]     opnd_i,
  output logic [2*MD_XLEN-1:0]   acc_o
);
  localparam int unsigned W = MD_XLEN;

  logic [W:0]   add_sum;
  logic         rem_ge;
  logic [W-1:0] rem_diff;

  always_comb begin
    add_sum  = {1'b0, acc_i[2*W-1:W]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Shifted partial remainder is 33 bits; its difference always fits in 32.
    rem_ge   = acc_i[2*W-1:W-1] >= {1'b0, opnd_i};
    rem_diff = acc_i[2*W-2:W-1] - opnd_i;
    if (!is_div_i) begin
      acc_o = {add_sum, acc_i[W-1:1]};
    end else if (rem_ge) begin
      acc_o = {rem_diff, acc_i[W-2:0], 1'b1};
    end else begin
      acc_o = {acc_i[2*W-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Iterative RV32M sequencer: latches magnitudes, runs 32 steps, fixes signs,
// and presents a one-cycle result to EX while stalling the pipeline.
module ex_muldiv_ctrl
  import ex_muldiv_ctrl_pkg::*;
#(
  parameter int unsigned XLEN  = MD_XLEN,
  parameter int unsigned CNT_W = MD_CNT_W
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            flush_i,
  output logic            stall_o,
  ex_muldiv_ctrl_if.slave ex
);
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept, s1, s2, div_zero, div_ovf;
  logic [XLEN-1:0]   mag1, mag2, quo, rem, fix_res;
  logic [2*XLEN-1:0] prod, step_acc;

  ex_muldiv_step u_step (
    .is_div_i (op_q[2]),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc)
  );

  always_comb begin
    accept   = (state_q == MD_IDLE) && ex.start_i && !flush_i;
    s1       = md_op1_signed(ex.op_i) & ex.op1_i[XLEN-1];
    s2       = md_op2_signed(ex.op_i) & ex.op2_i[XLEN-1];
    mag1     = s1 ? -ex.op1_i : ex.op1_i;
    mag2     = s2 ? -ex.op2_i : ex.op2_i;
    div_zero = md_is_div(ex.op_i) && (ex.op2_i == '0);
    div_ovf  = ((ex.op_i == INST_DIV) || (ex.op_i == INST_REM)) &&
               (ex.op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (ex.op2_i == '1);

    // One negate flag serves both product and quotient (signs differ).
    prod = neg_q ? -acc_q : acc_q;
    quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      INST_MUL:                          fix_res = prod[XLEN-1:0];
      INST_MULH, INST_MULHSU, INST_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      INST_DIV, INST_DIVU:               fix_res = quo;
      default:                           fix_res = rem;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    if (flush_i) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        MD_IDLE: if (accept) begin
          op_d      = ex.op_i;
          rd_d      = ex.reg_w_addr_i;
          cnt_d     = '0;
          neg_d     = s1 ^ s2;
          neg_rem_d = s1;
          opnd_d    = mag2;
          acc_d     = {{XLEN{1'b0}}, mag1};
          if (div_zero) begin
            result_d = ex.op_i[1] ? ex.op1_i : '1;
            state_d  = MD_DONE;
          end else if (div_ovf) begin
            result_d = ex.op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            state_d  = MD_DONE;
          end else begin
            state_d = MD_CALC;
          end
        end
        MD_CALC: begin
          acc_d = step_acc;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MD_ITER - 1)) state_d = MD_FIX;
        end
        MD_FIX: begin
          result_d = fix_res;
          state_d  = MD_DONE;
        end
        default: state_d = MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign stall_o           = accept || (state_q == MD_CALC) || (state_q == MD_FIX);
  assign ex.busy_o         = (state_q == MD_CALC) || (state_q == MD_FIX);
  assign ex.result_valid_o = (state_q == MD_DONE) && !flush_i;
  assign ex.result_o       = result_q;
  assign ex.reg_w_addr_o   = rd_q;
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: directed table, corner sequences
// and randomized operations against an arithmetic reference model.
module tb_ex_muldiv_ctrl;
  logic clk = 1'b0;
  logic arst = 1'b1;
  logic flush = 1'b0;
  logic stall;
  int   n_cmp = 0;
  int   n_err = 0;

  ex_muldiv_ctrl_if bus();

  ex_muldiv_ctrl #(.XLEN(32), .CNT_W(5)) dut (
    .clk     (clk),
    .arst    (arst),
    .flush_i (flush),
    .stall_o (stall),
    .ex      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issues one op at the next falling edge and follows it to its result pulse.
  // hold > 1 keeps start_i asserted with junk operands for hold-1 busy cycles.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int lat, input int hold);
    int k;
    bit seen, hold_ok;
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = op; bus.op1_i = a; bus.op2_i = b;
    bus.reg_w_addr_i = rd; flush = 1'b0;
    #1 check({nm, " stall_T0"}, 32'(stall), 32'd1);
    k = 0; seen = 0; hold_ok = 1;
    while (!seen && k < 60) begin
      @(negedge clk);
      k++;
      if (bus.result_valid_o) seen = 1;
      else if (!stall || !bus.busy_o) hold_ok = 0;
      if (!seen && k < hold) begin
        bus.start_i = 1'b1; bus.op_i = 3'($urandom);
        bus.op1_i = $urandom; bus.op2_i = $urandom; bus.reg_w_addr_i = 5'($urandom);
      end else begin
        bus.start_i = 1'b0;
      end
    end
    check({nm, " latency"}, 32'(seen ? k : -1), 32'(lat));
    check({nm, " result"}, bus.result_o, exp);
    check({nm, " rd"}, 32'(bus.reg_w_addr_o), 32'(rd));
    check({nm, " stall_busy_until_done"}, 32'(hold_ok), 32'd1);
    check({nm, " done_no_stall"}, 32'({stall, bus.busy_o}), 32'd0);
    @(negedge clk);
    check({nm, " one_pulse"}, 32'(bus.result_valid_o), 32'd0);
    check({nm, " result_hold"}, bus.result_o, exp);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic expect_no_valid(input string nm, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.result_valid_o) cnt++;
    end
    check(nm, 32'(cnt), 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.start_i = 1'b0; bus.op_i = '0; bus.op1_i = '0; bus.op2_i = '0;
    bus.reg_w_addr_i = '0;

    vt[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vt[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vt[2]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
    vt[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
    vt[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
    vt[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
    vt[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
    vt[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34};
    vt[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vt[9]  = '{3'd7, 32'd5,          32'd0,         32'd5,         1};
    vt[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vt[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1};
    vt[12] = '{3'd6, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 34};
    vt[13] = '{3'd4, 32'd20,         32'hFFFF_FFF9, 32'hFFFF_FFFE, 34};

    wait_cycles(2);
    check("reset valid", 32'(bus.result_valid_o), 32'd0);
    check("reset result", bus.result_o, 32'd0);
    check("reset rd", 32'(bus.reg_w_addr_o), 32'd0);
    check("reset busy_stall", 32'({bus.busy_o, stall}), 32'd0);
    arst = 1'b0;

    foreach (vt[i])
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, 5'(i + 1),
             vt[i].exp, vt[i].lat, 0);

    // start_i held high with junk while busy must not disturb the op in flight
    run_op("start_while_busy", 3'd0, 32'd1234, 32'd5678, 5'd9, 32'd7006652, 34, 10);

    // flush at counter 10 aborts, then a fresh MUL completes normally
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 3'd0; bus.op1_i = 32'd5; bus.op2_i = 32'd6;
    bus.reg_w_addr_i = 5'd3;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_cycles(10);
    check("flush pre busy", 32'(bus.busy_o), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush idle", 32'({bus.busy_o, stall, bus.result_valid_o}), 32'd0);
    run_op("after_flush", 3'd0, 32'd3, 32'd4, 5'd12, 32'd12, 34, 0);

    // flush during DONE masks the pulse that same cycle
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 3'd5; bus.op1_i = 32'd7; bus.op2_i = 32'd0;
    bus.reg_w_addr_i = 5'd4;
    @(negedge clk);
    bus.start_i = 1'b0;
    check("done valid", 32'(bus.result_valid_o), 32'd1);
    flush = 1'b1;
    #1 check("done flush valid", 32'(bus.result_valid_o), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    check("done flush idle", 32'({bus.busy_o, bus.result_valid_o}), 32'd0);

    // start and flush together in IDLE accept nothing
    run_op("pre_sf", 3'd0, 32'd9, 32'd9, 5'd21, 32'd81, 34, 0);
    @(negedge clk);
    bus.start_i = 1'b1; flush = 1'b1; bus.op_i = 3'd0; bus.op1_i = 32'd2;
    bus.op2_i = 32'd2; bus.reg_w_addr_i = 5'd30;
    #1 check("sf stall", 32'(stall), 32'd0);
    @(negedge clk);
    bus.start_i = 1'b0; flush = 1'b0;
    check("sf busy", 32'(bus.busy_o), 32'd0);
    check("sf rd unchanged", 32'(bus.reg_w_addr_o), 32'd21);
    expect_no_valid("sf no_result", 40);

    // asynchronous reset at counter 20
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 3'd5; bus.op1_i = 32'd1000; bus.op2_i = 32'd3;
    bus.reg_w_addr_i = 5'd17;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_cycles(20);
    arst = 1'b1;
    #1;
    check("arst busy_stall", 32'({bus.busy_o, stall}), 32'd0);
    check("arst result", bus.result_o, 32'd0);
    check("arst rd", 32'(bus.reg_w_addr_o), 32'd0);
    @(negedge clk);
    arst = 1'b0;
    expect_no_valid("arst no_result", 40);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom);
      a  = pick_operand();
      b  = pick_operand();
      run_op($sformatf("rnd%0d op%0d %h %h", i, op, a, b), op, a, b, 5'($urandom),
             model(op, a, b), model_lat(op, a, b), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
